// File: rtl/wb_ram_slave.sv
// Single-beat Wishbone responder for the on-chip RAM window, with a programmable
// number of wait states between accept and ack and a fault pulse for out-of-window accesses.
module wb_ram_slave #(
  parameter logic [31:0] BASE_ADDR   = 32'hb000_0000,
  parameter int unsigned DEPTH_WORDS = 16384,
  parameter int unsigned WAIT_STATES = 1,
  parameter string       INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  input  logic        i_wb_we,
  input  logic [31:0] i_wb_addr,
  input  logic [31:0] i_wb_data,
  output logic [31:0] o_wb_data,
  output logic        o_wb_ack,
  output logic        o_wb_stall,
  output logic        o_fault
);

  localparam int unsigned AW       = $clog2(DEPTH_WORDS);
  localparam logic [29:0] BaseWord = BASE_ADDR[31:2];
  localparam logic [29:0] Depth30  = 30'(DEPTH_WORDS);
  localparam logic [3:0]  WaitInit = 4'(WAIT_STATES);

  typedef enum logic [1:0] {StIdle, StWait, StAck} state_e;

  state_e        state_q;
  logic [3:0]    cnt_q;
  logic          we_q;
  logic          in_range_q;
  logic [AW-1:0] idx_q;
  logic [31:0]   wdata_q;
  logic [31:0]   rdata_q;
  logic          ack_q;
  logic          stall_q;
  logic          fault_q;

  logic [31:0]   mem [DEPTH_WORDS];

  logic [29:0]   word_off;
  logic          addr_in_range;
  logic          accept;
  logic          finish;
  logic          mem_we;

  // Word offset only matters once addr >= BASE_ADDR, so the subtraction cannot wrap there.
  always_comb begin
    word_off      = i_wb_addr[31:2] - BaseWord;
    addr_in_range = (i_wb_addr >= BASE_ADDR) && (word_off < Depth30);
    accept        = (state_q == StIdle) && i_wb_cyc && i_wb_stb;
    finish        = (state_q == StWait) && i_wb_cyc && (cnt_q == 4'd0);
    mem_we        = !reset && finish && we_q && in_range_q;
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[idx_q] <= wdata_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= 4'd0;
      we_q       <= 1'b0;
      in_range_q <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= 32'h0;
      rdata_q    <= 32'h0;
      ack_q      <= 1'b0;
      stall_q    <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      ack_q   <= 1'b0;
      fault_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          stall_q <= 1'b0;
          if (accept) begin
            state_q    <= StWait;
            cnt_q      <= WaitInit;
            we_q       <= i_wb_we;
            in_range_q <= addr_in_range;
            idx_q      <= word_off[AW-1:0];
            wdata_q    <= i_wb_data;
            stall_q    <= 1'b1;
          end
        end
        StWait: begin
          if (!i_wb_cyc) begin
            // Master abandoned the cycle: drop it silently.
            state_q <= StIdle;
            stall_q <= 1'b0;
          end else if (cnt_q == 4'd0) begin
            state_q <= StAck;
            ack_q   <= 1'b1;
            fault_q <= !in_range_q;
            if (!we_q) begin
              rdata_q <= in_range_q ? mem[idx_q] : 32'h0;
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StAck: begin
          state_q <= StIdle;
          stall_q <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          stall_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_wb_data  = rdata_q;
  assign o_wb_ack   = ack_q;
  assign o_wb_stall = stall_q;
  assign o_fault    = fault_q;

endmodule

// File: tb/tb_wb_ram_slave.sv
// Directed bench for wb_ram_slave: four instances (WAIT_STATES 1, 0, 3, 15) share the bus
// signals but each has its own cyc, so only the selected one ever sees a cycle.
module tb_wb_ram_slave;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  cyc;
  logic        stb;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata [4];
  logic        ack   [4];
  logic        stall [4];
  logic        fault [4];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int unsigned Ws = (g == 0) ? 1 : (g == 1) ? 0 : (g == 2) ? 3 : 15;
    wb_ram_slave #(.WAIT_STATES(Ws)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .i_wb_cyc  (cyc[g]),
      .i_wb_stb  (stb),
      .i_wb_we   (we),
      .i_wb_addr (addr),
      .i_wb_data (wdata),
      .o_wb_data (rdata[g]),
      .o_wb_ack  (ack[g]),
      .o_wb_stall(stall[g]),
      .o_fault   (fault[g])
    );
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One complete single-beat access; returns read data, fault and accept-to-ack latency.
  task automatic bus_access(input int sel, input logic w, input logic [31:0] a,
                            input logic [31:0] d, output logic [31:0] rd,
                            output logic flt, output int lat);
    @(negedge clk);
    cyc[sel] = 1'b1;
    stb      = 1'b1;
    we       = w;
    addr     = a;
    wdata    = d;
    @(posedge clk);
    #1;
    // Scramble the bus after accept; the latched request must be what completes.
    stb   = 1'b0;
    we    = ~w;
    addr  = a ^ 32'h0000_0040;
    wdata = ~d;
    lat   = 0;
    rd    = 32'h0;
    flt   = 1'b0;
    while (lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      check_eq("stall_busy", 32'(stall[sel]), 32'd1);
      if (ack[sel]) break;
    end
    if (!ack[sel]) check_eq("ack_timeout", 32'd0, 32'd1);
    rd  = rdata[sel];
    flt = fault[sel];
    @(posedge clk);
    #1;
    check_eq("ack_once", 32'(ack[sel]), 32'd0);
    check_eq("stall_idle", 32'(stall[sel]), 32'd0);
    cyc[sel] = 1'b0;
  endtask

  logic [31:0] rd;
  logic        flt;
  int          lat;
  logic [31:0] b2b_val [4];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    cyc   = 4'b0;
    stb   = 1'b0;
    we    = 1'b0;
    addr  = 32'h0;
    wdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check_eq("rst_ack", 32'(ack[0]), 32'd0);
    check_eq("rst_stall", 32'(stall[0]), 32'd0);
    check_eq("rst_fault", 32'(fault[0]), 32'd0);
    check_eq("rst_data", rdata[0], 32'h0);

    // Reset mid-WAIT discards the pending write.
    bus_access(0, 1'b1, 32'hb000_0030, 32'h1111_1111, rd, flt, lat);
    bus_access(0, 1'b0, 32'hb000_0030, 32'h0, rd, flt, lat);
    check_eq("pre_rst_rd", rd, 32'h1111_1111);
    @(negedge clk);
    cyc[0] = 1'b1; stb = 1'b1; we = 1'b1; addr = 32'hb000_0030; wdata = 32'hdead_beef;
    @(posedge clk);
    #1;
    stb = 1'b0; reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check_eq("rst_mid_ack", 32'(ack[0]), 32'd0);
    end
    reset = 1'b0; cyc[0] = 1'b0;
    @(posedge clk);
    #1;
    check_eq("rst_mid_stall", 32'(stall[0]), 32'd0);
    check_eq("rst_mid_data", rdata[0], 32'h0);
    check_eq("rst_mid_ack2", 32'(ack[0]), 32'd0);
    bus_access(0, 1'b0, 32'hb000_0030, 32'h0, rd, flt, lat);
    check_eq("rst_word_kept", rd, 32'h1111_1111);

    // Basic write/read with one wait state.
    bus_access(0, 1'b1, 32'hb000_0010, 32'hcafe_f00d, rd, flt, lat);
    check_eq("wr_lat", 32'(lat), 32'd2);
    check_eq("wr_fault", 32'(flt), 32'd0);
    bus_access(0, 1'b0, 32'hb000_0010, 32'h0, rd, flt, lat);
    check_eq("rd_lat", 32'(lat), 32'd2);
    check_eq("rd_data", rd, 32'hcafe_f00d);
    bus_access(0, 1'b0, 32'hb000_0013, 32'h0, rd, flt, lat);
    check_eq("misaligned_rd", rd, 32'hcafe_f00d);

    // Wait-state sweep: WAIT_STATES 0, 3, 15 give latencies 1, 4, 16.
    for (int s = 1; s < 4; s++) begin
      int exp_lat;
      exp_lat = (s == 1) ? 1 : (s == 2) ? 4 : 16;
      bus_access(s, 1'b1, 32'hb000_0000, 32'ha5a5_0000 + 32'(s), rd, flt, lat);
      check_eq("ws_wr_lat", 32'(lat), 32'(exp_lat));
      bus_access(s, 1'b0, 32'hb000_0000, 32'h0, rd, flt, lat);
      check_eq("ws_rd_lat", 32'(lat), 32'(exp_lat));
      check_eq("ws_rd_data", rd, 32'ha5a5_0000 + 32'(s));
    end

    // Window boundaries.
    bus_access(0, 1'b1, 32'hb000_0000, 32'h0bad_f00d, rd, flt, lat);
    bus_access(0, 1'b1, 32'hb000_fffc, 32'h1234_5678, rd, flt, lat);
    check_eq("top_wr_fault", 32'(flt), 32'd0);
    bus_access(0, 1'b0, 32'hb000_fffc, 32'h0, rd, flt, lat);
    check_eq("top_rd", rd, 32'h1234_5678);
    check_eq("top_rd_fault", 32'(flt), 32'd0);
    bus_access(0, 1'b1, 32'hb001_0000, 32'hdead_beef, rd, flt, lat);
    check_eq("oob_wr_fault", 32'(flt), 32'd1);
    bus_access(0, 1'b0, 32'hafff_fffc, 32'h0, rd, flt, lat);
    check_eq("oob_rd_fault", 32'(flt), 32'd1);
    check_eq("oob_rd_data", rd, 32'h0);
    bus_access(0, 1'b0, 32'hb000_0000, 32'h0, rd, flt, lat);
    check_eq("oob_no_alias0", rd, 32'h0bad_f00d);
    bus_access(0, 1'b0, 32'hb000_fffc, 32'h0, rd, flt, lat);
    check_eq("oob_no_alias_top", rd, 32'h1234_5678);

    // Abort: cyc dropped in WAIT.
    bus_access(0, 1'b1, 32'hb000_0020, 32'h55aa_55aa, rd, flt, lat);
    @(negedge clk);
    cyc[0] = 1'b1; stb = 1'b1; we = 1'b1; addr = 32'hb000_0020; wdata = 32'hffff_ffff;
    @(posedge clk);
    #1;
    stb = 1'b0; cyc[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_eq("abort_ack", 32'(ack[0]), 32'd0);
      check_eq("abort_fault", 32'(fault[0]), 32'd0);
    end
    bus_access(0, 1'b0, 32'hb000_0020, 32'h0, rd, flt, lat);
    check_eq("abort_rd", rd, 32'h55aa_55aa);

    // Back-to-back reads with stb held: one accept every 4 cycles (accept, 2x WAIT, ACK).
    for (int i = 0; i < 4; i++) begin
      b2b_val[i] = 32'h1111_0000 | 32'(i);
      bus_access(0, 1'b1, 32'hb000_fff0 + 32'(4 * i), b2b_val[i], rd, flt, lat);
    end
    begin
      int   n_acc;
      int   n_ack;
      int   last_acc;
      logic st_before;
      logic stb_before;
      n_acc = 0; n_ack = 0; last_acc = -1;
      @(negedge clk);
      cyc[0] = 1'b1; stb = 1'b1; we = 1'b0; addr = 32'hb000_fff0;
      for (int c = 0; c < 60 && n_ack < 4; c++) begin
        st_before  = stall[0];
        stb_before = stb;
        @(posedge clk);
        #1;
        if (stb_before && !st_before) begin
          if (last_acc >= 0) check_eq("b2b_spacing", 32'(c - last_acc), 32'd4);
          last_acc = c;
          n_acc++;
          if (n_acc < 4) addr = 32'hb000_fff0 + 32'(4 * n_acc);
          else stb = 1'b0;
        end
        if (ack[0]) begin
          check_eq("b2b_data", rdata[0], b2b_val[n_ack]);
          check_eq("b2b_ack_stall", 32'(stall[0]), 32'd1);
          n_ack++;
        end
      end
      @(posedge clk);
      #1;
      cyc[0] = 1'b0;
      check_eq("b2b_accepts", 32'(n_acc), 32'd4);
      check_eq("b2b_acks", 32'(n_ack), 32'd4);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
